// File: rtl/shared_memory_pkg.sv
// Shared types and width defaults for the shared-memory arbiter block.
package shared_memory_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 4;
  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [0:0] {INIT, ARB} state_e;
  typedef enum logic [0:0] {PORT_A, PORT_B} port_e;

endpackage

// File: rtl/shared_memory_arbiter_if.sv
// Requester ports A/B and the single memory port, bundled for the arbiter.
interface shared_memory_arbiter_if #(
  parameter int unsigned ADDR_W = shared_memory_pkg::DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = shared_memory_pkg::DEFAULT_DATA_W
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              init_done;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output init_done
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  init_done
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer names the port favoured on a tie.
module rr_arbiter_2
  import shared_memory_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_e ptr_q, ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = (ptr_q == PORT_A) ? 2'b01 : 2'b10;
    end
    // After serving A, favour B next time, and vice versa.
    if (advance) begin
      ptr_d = gnt[0] ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PORT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Clears the shared memory after reset, then serialises port A/B accesses onto it.
module shared_memory_arbiter
  import shared_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_memory_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        req, arb_gnt, gnt;
  logic              xfer;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              hold_we_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_wdata_q;

  logic              rv_valid_q, rv_valid_d;
  port_e             rv_port_q, rv_port_d;

  assign req = {bus.b_req, bus.a_req};

  rr_arbiter_2 u_rr_arbiter_2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (xfer),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt        = 2'b00;
    mem_en     = 1'b0;
    mem_we     = hold_we_q;
    mem_addr   = hold_addr_q;
    mem_wdata  = hold_wdata_q;
    rv_valid_d = 1'b0;
    rv_port_d  = rv_port_q;
    unique case (state_q)
      INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ARB;
        end
      end
      ARB: begin
        gnt = arb_gnt;
        if (gnt != 2'b00) begin
          mem_en     = 1'b1;
          mem_we     = gnt[1] ? bus.b_we    : bus.a_we;
          mem_addr   = gnt[1] ? bus.b_addr  : bus.a_addr;
          mem_wdata  = gnt[1] ? bus.b_wdata : bus.a_wdata;
          rv_valid_d = ~mem_we;
          rv_port_d  = gnt[1] ? PORT_B : PORT_A;
        end
      end
      default: ;
    endcase
    // Reset wins over everything: no strobe, no grant, nothing tagged for rvalid.
    if (rst) begin
      gnt        = 2'b00;
      mem_en     = 1'b0;
      rv_valid_d = 1'b0;
    end
    xfer = gnt != 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      rv_valid_q   <= 1'b0;
      rv_port_q    <= PORT_A;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rv_valid_q   <= rv_valid_d;
      rv_port_q    <= rv_port_d;
      hold_we_q    <= mem_we;
      hold_addr_q  <= mem_addr;
      hold_wdata_q <= mem_wdata;
    end
  end

  assign bus.a_gnt     = gnt[0];
  assign bus.b_gnt     = gnt[1];
  assign bus.a_rvalid  = rv_valid_q && (rv_port_q == PORT_A) && !rst;
  assign bus.b_rvalid  = rv_valid_q && (rv_port_q == PORT_B) && !rst;
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.b_rdata   = bus.mem_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.init_done = state_q == ARB;

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Random and directed stimulus against a reference model; a negedge monitor scores the DUT.
module tb_shared_memory_arbiter;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shared_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  shared_memory_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state
  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc      = 0;
  int            init_cnt = 0;
  bit            last_a   = 1'b0;
  bit            a_took   = 1'b0;
  bit            b_took   = 1'b0;
  bit            prev_ok  = 1'b0;
  logic          prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    exp_t          e;
    bit            ea, eb, due;
    logic          we_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    cyc++;
    a_took = bus.a_req && bus.a_gnt;
    b_took = bus.b_req && bus.b_gnt;
    if (rst) begin
      check("rst_gnt", {bus.a_gnt, bus.b_gnt}, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
      q_a.delete();
      q_b.delete();
      init_cnt = 0;
      last_a   = 1'b0;
      prev_ok  = 1'b0;
    end else begin
      due = q_a.size() != 0 && q_a[0].cyc == cyc - 1;
      check("a_rvalid", bus.a_rvalid, due);
      if (due) begin
        e = q_a.pop_front();
        if (bus.a_rvalid) check("a_rdata", bus.a_rdata, e.data);
      end
      due = q_b.size() != 0 && q_b[0].cyc == cyc - 1;
      check("b_rvalid", bus.b_rvalid, due);
      if (due) begin
        e = q_b.pop_front();
        if (bus.b_rvalid) check("b_rdata", bus.b_rdata, e.data);
      end

      if (init_cnt < DEPTH) begin
        check("init_done_low", bus.init_done, 0);
        check("init_gnt", {bus.a_gnt, bus.b_gnt}, 0);
        check("init_mem_en", bus.mem_en, 1);
        check("init_mem_we", bus.mem_we, 1);
        check("init_mem_addr", bus.mem_addr, init_cnt);
        check("init_mem_wdata", bus.mem_wdata, 0);
        ref_mem[init_cnt] = '0;
        init_cnt++;
      end else begin
        check("init_done", bus.init_done, 1);
        // Lone requester wins; on a tie the port not served last wins.
        ea = bus.a_req && (!bus.b_req || !last_a);
        eb = bus.b_req && (!bus.a_req || last_a);
        check("a_gnt", bus.a_gnt, ea);
        check("b_gnt", bus.b_gnt, eb);
        if (ea || eb) begin
          we_s    = ea ? bus.a_we    : bus.b_we;
          addr_s  = ea ? bus.a_addr  : bus.b_addr;
          wdata_s = ea ? bus.a_wdata : bus.b_wdata;
          check("mem_en", bus.mem_en, 1);
          check("mem_we", bus.mem_we, we_s);
          check("mem_addr", bus.mem_addr, addr_s);
          if (we_s) begin
            check("mem_wdata", bus.mem_wdata, wdata_s);
            ref_mem[addr_s] = wdata_s;
          end else begin
            e.cyc  = cyc;
            e.data = ref_mem[addr_s];
            if (ea) q_a.push_back(e);
            else q_b.push_back(e);
          end
          last_a = ea;
        end else begin
          check("mem_en_idle", bus.mem_en, 0);
          if (prev_ok) begin
            check("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                  {prev_we, prev_addr, prev_wdata});
          end
        end
      end
      prev_ok    = 1'b1;
      prev_we    = bus.mem_we;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_took) bus.a_req = 1'b0;
    if (b_took) bus.b_req = 1'b0;
  endtask

  // Caller guarantees the port is idle so fields never change under a pending req.
  task automatic drive(input bit p, input bit we, input int addr, input int data);
    if (!p) begin
      bus.a_req   = 1'b1;
      bus.a_we    = we;
      bus.a_addr  = AW'(addr);
      bus.a_wdata = DW'(data);
    end else begin
      bus.b_req   = 1'b1;
      bus.b_we    = we;
      bus.b_addr  = AW'(addr);
      bus.b_wdata = DW'(data);
    end
  endtask

  task automatic settle();
    int n = 0;
    while ((bus.a_req || bus.b_req) && n < 64) begin
      tick();
      n++;
    end
    check("settle_timeout", {bus.a_req, bus.b_req}, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // B read held across the whole clear sequence.
    drive(1, 0, 5, 0);
    tick();
    rst = 1'b0;
    settle();

    // Same-cycle writes to one address, then read back the later winner.
    drive(0, 1, 7, 'h11);
    drive(1, 1, 7, 'h22);
    settle();
    drive(0, 0, 7, 0);
    settle();

    drive(0, 1, 3, 'hA5);
    settle();
    drive(0, 0, 3, 0);
    settle();

    // Both ports read back to back.
    repeat (8) begin
      if (!bus.a_req) drive(0, 0, $urandom_range(0, 15), 0);
      if (!bus.b_req) drive(1, 0, $urandom_range(0, 15), 0);
      tick();
    end
    settle();

    repeat (300) begin
      if (!bus.a_req && $urandom_range(0, 1) == 1)
        drive(0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255));
      if (!bus.b_req && $urandom_range(0, 1) == 1)
        drive(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255));
      tick();
    end
    settle();

    // Reset lands in the cycle A's read would be granted; data must come back cleared.
    drive(0, 1, 9, 'h5C);
    settle();
    drive(0, 0, 9, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    drive(1, 0, 3, 0);
    settle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_memory_arbiter.md
# shared_memory_arbiter

Two-requester round-robin arbiter and init sequencer in front of a single-port 16x8 shared memory. It serialises port A and port B accesses onto one memory port, so same-cycle write collisions cannot occur. After every reset it clears the memory by walking all addresses. Requesters see a req/gnt handshake and a registered read-valid strobe.

## Interface
- ADDR_W, 4, memory address width
- DATA_W, 8, data width
- DEPTH, 1<<ADDR_W, number of words cleared by the init sequence
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- a_req / b_req  in  1  access request; hold with stable fields until gnt
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  access address
- a_wdata / b_wdata  in  DATA_W  write data
- a_gnt / b_gnt  out  1  combinational grant; req&gnt = transfer this cycle
- a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse
- a_rdata / b_rdata  out  DATA_W  read data, meaningful only while rvalid=1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered in memory, valid 1 cycle after a read strobe
- init_done  out  1  high once the clear sequence is complete

## Operation
- States:
  - INIT: counter cnt runs 0..DEPTH-1. Each cycle drive mem_en=1, mem_we=1, mem_addr=cnt, mem_wdata=0. After cnt=DEPTH-1, go to ARB.
  - ARB: normal arbitration.
- While rst=1: mem_en=0 and both gnt=0.
- In INIT, a_gnt=b_gnt=0. Requests stay pending; none are lost.
- In ARB, at most one grant per cycle:
  - Only one req high: grant it.
  - Both high: grant the port not granted last. Pointer resets to favour A.
  - The pointer updates only on a transfer.
- On a transfer, drive mem_en=1, with mem_we/mem_addr/mem_wdata taken from the granted port.
- With no transfer, mem_en=0. mem_we, mem_addr and mem_wdata are don't-care but must be held stable.
- Read transfer: the granted port's rvalid pulses the following cycle, with rdata=mem_rdata (pass-through).
- Write transfer: no rvalid.
- Ordering is strictly grant order. A read granted the cycle after a write to the same address returns the new data.
- Fairness: with both ports requesting continuously, grants alternate A,B,A,B. Maximum wait is one transfer.

## Timing
- Reset values: init_done=0, a_rvalid=b_rvalid=0, gnt=0, cnt=0, pointer favours A. rdata is don't-care.
- First clear write occurs in the first cycle after rst deasserts.
- init_done rises in the cycle after the last clear write (DEPTH+1 cycles after rst deasserts). It then stays 1 until the next rst.
- A first grant is possible in the same cycle init_done is first 1.
- Read latency: gnt in cycle N, rvalid in N+1. A back-to-back read throughput of one per cycle is sustained.
- rst mid-INIT restarts the clear sequence at address 0.
- rst in ARB:
  - A read granted in the cycle rst rises is dropped (no rvalid).
  - A pending rvalid is cleared.
  - The block re-enters INIT.

## Structure
- Package shared_memory_pkg holds:
  - ADDR_W/DATA_W defaults
  - state enum {INIT, ARB}
  - port-select enum {PORT_A, PORT_B}
- Sub-module rr_arbiter_2: 2-way round-robin with pointer register, inputs req[1:0] and advance, output gnt[1:0].
- Top level: INIT counter, mux to memory, rvalid tag register (valid + port).

## Test plan
- Reset release: expect 16 writes of 0x00 to addresses 0..15 on consecutive cycles; init_done=1 at cycle 17; no gnt before that.
- A writes 0xA5 to addr 3, then A reads addr 3: gnt on each, a_rvalid one cycle after the read grant with a_rdata=0xA5; b_rvalid stays 0.
- A and B both write addr 7 (A=0x11, B=0x22) in the same cycle, pointer at reset: A granted first, then B; a subsequent read of addr 7 returns 0x22.
- Both ports issue continuous reads for 8 cycles: grants alternate A,B,A,B; each rvalid is on the correct port, one cycle after its grant.
- Request held during INIT: B read of addr 5 asserted at reset release is granted on the first ARB cycle and returns 0x00.
- rst asserted during the cycle A is granted a read: no a_rvalid; init_done drops and the 16-cycle clear repeats; previously written data reads back 0x00.
